// File: rtl/fb_pkg.sv
// Shared FREEDM bus transmit definitions: SoC codes, frame types, FSM states
// and the nibble-serial CRC-8 step.
package fb_pkg;

    localparam logic [3:0] FB_SOC_DATA      = 4'd7;
    localparam logic [3:0] FB_SOC_NUMB      = 4'd6;
    localparam logic [3:0] FB_SOC_DIST      = 4'd4;
    localparam logic [3:0] FB_SOC_DELAY     = 4'd3;
    localparam logic [3:0] FB_SOC_DELAYDIST = 4'd2;
    localparam logic [3:0] FB_PREAMBLE_NIB  = 4'h5;

    localparam logic [7:0] FB_CRC_INIT = 8'hFF;
    localparam logic [7:0] FB_CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        FB_TYPE_DATA      = 3'd0,
        FB_TYPE_NUMB      = 3'd1,
        FB_TYPE_DIST      = 3'd2,
        FB_TYPE_DELAY     = 3'd3,
        FB_TYPE_DELAYDIST = 3'd4
    } fb_type_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SOC      = 3'd2,
        ST_DATA     = 3'd3,
        ST_FRMCRC   = 3'd4,
        ST_IFG      = 3'd5
    } fb_state_e;

    function automatic logic [3:0] fb_soc_code(input fb_type_e t);
        case (t)
            FB_TYPE_NUMB:      return FB_SOC_NUMB;
            FB_TYPE_DIST:      return FB_SOC_DIST;
            FB_TYPE_DELAY:     return FB_SOC_DELAY;
            FB_TYPE_DELAYDIST: return FB_SOC_DELAYDIST;
            default:           return FB_SOC_DATA;
        endcase
    endfunction

    // One serial bit into the CRC register, bit shifted in at the MSB side.
    function automatic logic [7:0] fb_crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? FB_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/fb_crc.sv
// Nibble-wide CRC-8 accumulator; nibble bit 3 is consumed first.
module fb_crc
    import fb_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Data,
    input  logic       Enable,
    input  logic       Initialize,
    output logic [7:0] Crc
);

    logic [7:0] crc_d;
    logic [7:0] crc_q;

    always_comb begin
        crc_d = crc_q;
        if (Initialize) begin
            crc_d = FB_CRC_INIT;
        end else if (Enable) begin
            crc_d = fb_crc_step(fb_crc_step(fb_crc_step(fb_crc_step(crc_q,
                        Data[3]), Data[2]), Data[1]), Data[0]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) crc_q <= FB_CRC_INIT;
        else       crc_q <= crc_d;
    end

    assign Crc = crc_q;

endmodule

// File: rtl/fb_txmac.sv
// FREEDM bus nibble transmit MAC: preamble, SoC, payload (low nibble first),
// inverted CRC-8, then inter-frame gap.
module fb_txmac
    import fb_pkg::*;
#(
    parameter int PREAMBLE_NIBS = 7,
    parameter int IFG_NIBS      = 4
) (
    input  logic       MTxClk,
    input  logic       Reset,
    input  logic       TxStart,
    input  logic [2:0] TxType,
    input  logic [7:0] TxLen,
    input  logic [7:0] TxData,
    output logic       TxDataReq,
    input  logic       TxAbort,
    output logic       MTxEn,
    output logic [3:0] MTxD,
    output logic       TxBusy,
    output logic       TxDone,
    output logic       StateIdle,
    output logic       StatePreamble,
    output logic       StateSoC,
    output logic       StateData,
    output logic       StateFrmCrc,
    output logic       StateIfg
);

    fb_state_e  state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    fb_type_e   type_q, type_d;
    logic [7:0] len_q, len_d;
    logic [7:0] byte_q, byte_d;
    logic       mtxen_q, mtxen_d;
    logic [3:0] mtxd_q, mtxd_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [5:0] flags_q, flags_d;
    logic [7:0] crc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        len_d   = len_q;
        // A strobe in the previous cycle means TxData is captured at this edge.
        byte_d  = req_q ? TxData : byte_q;
        done_d  = 1'b0;
        mtxen_d = 1'b0;
        mtxd_d  = 4'h0;
        req_d   = 1'b0;
        flags_d = 6'b000000;

        case (state_q)
            ST_IDLE: begin
                if (TxStart && (TxType <= FB_TYPE_DELAYDIST)) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = 9'd0;
                    type_d  = fb_type_e'(TxType);
                    len_d   = TxLen;
                end
            end
            ST_PREAMBLE: begin
                if (TxAbort) begin
                    state_d = ST_IFG;
                    cnt_d   = 9'd0;
                end else if (cnt_q == 9'(PREAMBLE_NIBS - 1)) begin
                    state_d = ST_SOC;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_SOC: begin
                cnt_d   = 9'd0;
                state_d = TxAbort ? ST_IFG : ((len_q != 8'd0) ? ST_DATA : ST_FRMCRC);
            end
            ST_DATA: begin
                if (TxAbort) begin
                    state_d = ST_IFG;
                    cnt_d   = 9'd0;
                end else if (cnt_q == ({len_q, 1'b0} - 9'd1)) begin
                    state_d = ST_FRMCRC;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_FRMCRC: begin
                if (TxAbort) begin
                    state_d = ST_IFG;
                    cnt_d   = 9'd0;
                end else if (cnt_q == 9'd1) begin
                    state_d = ST_IFG;
                    cnt_d   = 9'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_IFG: begin
                if (cnt_q == 9'(IFG_NIBS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 9'd0;
            end
        endcase

        // Outputs are decoded from the next state so they line up with state_q.
        case (state_d)
            ST_PREAMBLE: begin
                mtxen_d = 1'b1;
                mtxd_d  = FB_PREAMBLE_NIB;
                flags_d = 6'b000010;
            end
            ST_SOC: begin
                mtxen_d = 1'b1;
                mtxd_d  = fb_soc_code(type_q);
                req_d   = (len_q != 8'd0);
                flags_d = 6'b000100;
            end
            ST_DATA: begin
                mtxen_d = 1'b1;
                mtxd_d  = cnt_d[0] ? byte_q[7:4] : byte_d[3:0];
                req_d   = cnt_d[0] && (cnt_d[8:1] != (len_q - 8'd1));
                flags_d = 6'b001000;
            end
            ST_FRMCRC: begin
                mtxen_d = 1'b1;
                flags_d = 6'b010000;
            end
            ST_IFG:  flags_d = 6'b100000;
            default: flags_d = 6'b000001;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge MTxClk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            mtxen_q <= 1'b0;
            mtxd_q  <= 4'h0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= 6'b000001;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mtxen_q <= mtxen_d;
            mtxd_q  <= mtxd_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge MTxClk) begin
        type_q <= type_d;
        len_q  <= len_d;
        byte_q <= byte_d;
    end

    fb_crc u_crc (
        .Clk        (MTxClk),
        .Reset      (~Reset),
        .Data       (mtxd_q),
        .Enable     (mtxen_q && (state_q != ST_FRMCRC)),
        .Initialize (state_q == ST_IDLE),
        .Crc        (crc)
    );

    // CRC nibbles come straight from the held CRC register, which only settles
    // at the edge that enters FRMCRC.
    always_comb begin
        MTxD = mtxd_q;
        if (state_q == ST_FRMCRC) begin
            MTxD = cnt_q[0] ? {~crc[0], ~crc[1], ~crc[2], ~crc[3]}
                            : {~crc[4], ~crc[5], ~crc[6], ~crc[7]};
        end
    end

    assign MTxEn         = mtxen_q;
    assign TxDataReq     = req_q;
    assign TxBusy        = busy_q;
    assign TxDone        = done_q;
    assign StateIdle     = flags_q[0];
    assign StatePreamble = flags_q[1];
    assign StateSoC      = flags_q[2];
    assign StateData     = flags_q[3];
    assign StateFrmCrc   = flags_q[4];
    assign StateIfg      = flags_q[5];

endmodule

// File: tb/tb_fb_txmac.sv
// Randomized self-checking bench for fb_txmac against a frame-level reference
// model: expected nibble stream, strobe count, TxDone and IFG length.
module tb_fb_txmac;

    localparam int PRE = 7;
    localparam int IFG = 4;

    logic       MTxClk = 1'b0;
    logic       Reset;
    logic       TxStart;
    logic [2:0] TxType;
    logic [7:0] TxLen;
    logic [7:0] TxData;
    logic       TxDataReq;
    logic       TxAbort;
    logic       MTxEn;
    logic [3:0] MTxD;
    logic       TxBusy;
    logic       TxDone;
    logic       StateIdle, StatePreamble, StateSoC, StateData, StateFrmCrc, StateIfg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pay [256];
    logic [3:0] soc_tab [5] = '{4'd7, 4'd6, 4'd4, 4'd3, 4'd2};

    fb_txmac #(.PREAMBLE_NIBS(PRE), .IFG_NIBS(IFG)) dut (
        .MTxClk        (MTxClk),
        .Reset         (Reset),
        .TxStart       (TxStart),
        .TxType        (TxType),
        .TxLen         (TxLen),
        .TxData        (TxData),
        .TxDataReq     (TxDataReq),
        .TxAbort       (TxAbort),
        .MTxEn         (MTxEn),
        .MTxD          (MTxD),
        .TxBusy        (TxBusy),
        .TxDone        (TxDone),
        .StateIdle     (StateIdle),
        .StatePreamble (StatePreamble),
        .StateSoC      (StateSoC),
        .StateData     (StateData),
        .StateFrmCrc   (StateFrmCrc),
        .StateIfg      (StateIfg)
    );

    always #5 MTxClk = ~MTxClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // CRC-8, polynomial x^8+x^2+x+1, init FF, nibble MSB first.
    function automatic logic [7:0] crc_nib(input logic [7:0] c, input logic [3:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            if (r[7] ^ d[i]) r = (r << 1) ^ 8'h07;
            else             r = r << 1;
        end
        return r;
    endfunction

    task automatic run_frame(input string name, input int t, input int l,
                             input int abort_k, input bit poke);
        logic [3:0] exp_q[$];
        logic [3:0] got_q[$];
        logic [7:0] c;
        int nreq = 0, idx = 0, busy_idle = 0, ndone = 0, low_nz = 0, cyc = 0;
        int exp_len, exp_req, n, bad;
        bit finished = 0, seen_low = 0, done_first = 0;

        for (int i = 0; i < PRE; i++) exp_q.push_back(4'h5);
        exp_q.push_back(soc_tab[t]);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(pay[i][3:0]);
            exp_q.push_back(pay[i][7:4]);
        end
        c = 8'hFF;
        foreach (exp_q[i]) c = crc_nib(c, exp_q[i]);
        exp_q.push_back({~c[4], ~c[5], ~c[6], ~c[7]});
        exp_q.push_back({~c[0], ~c[1], ~c[2], ~c[3]});

        if (abort_k >= 0) begin
            exp_len = PRE + 1 + abort_k + 1;
            exp_req = 1;
            for (int j = 0; j <= abort_k; j++)
                if ((j % 2 == 1) && (j / 2 < l - 1)) exp_req++;
        end else begin
            exp_len = exp_q.size();
            exp_req = l;
        end

        @(negedge MTxClk);
        TxStart = 1'b1;
        TxType  = 3'(t);
        TxLen   = 8'(l);
        @(negedge MTxClk);
        TxStart = 1'b0;
        TxType  = 3'($urandom);
        TxLen   = 8'($urandom);

        while (!finished && cyc < 1000) begin
            TxData = pay[idx];
            if (TxDataReq === 1'b1) begin
                nreq++;
                if (idx < 255) idx++;
            end
            TxAbort = 1'b0;
            if (MTxEn === 1'b1) begin
                got_q.push_back(MTxD);
                if (abort_k >= 0 && got_q.size() == exp_len) TxAbort = 1'b1;
            end else begin
                if (MTxD !== 4'h0) low_nz++;
                if (TxBusy === 1'b1) busy_idle++;
                if (!seen_low) begin
                    seen_low   = 1;
                    done_first = (TxDone === 1'b1);
                end
            end
            if (TxDone === 1'b1) ndone++;
            TxStart = poke && (MTxEn === 1'b1) && ($urandom_range(0, 1) == 1);
            if (TxBusy !== 1'b1) finished = 1;
            else begin
                @(negedge MTxClk);
                cyc++;
            end
        end
        TxAbort = 1'b0;
        TxStart = 1'b0;

        check({name, "_finished"}, finished, 1);
        check({name, "_en_len"}, got_q.size(), exp_len);
        n = (got_q.size() < exp_len) ? got_q.size() : exp_len;
        bad = -1;
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        if (bad >= 0)
            check($sformatf("%s_nib%0d", name, bad), got_q[bad], exp_q[bad]);
        else if (n > 0)
            check({name, "_nib_last"}, got_q[n-1], exp_q[n-1]);
        check({name, "_req"}, nreq, exp_req);
        check({name, "_done_cnt"}, ndone, (abort_k >= 0) ? 0 : 1);
        check({name, "_done_pos"}, done_first, (abort_k >= 0) ? 0 : 1);
        check({name, "_ifg"}, busy_idle, IFG);
        check({name, "_d_idle"}, low_nz, 0);
        check({name, "_idle_flag"}, StateIdle, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        Reset   = 1'b0;
        TxStart = 1'b0;
        TxType  = 3'd0;
        TxLen   = 8'd0;
        TxData  = 8'd0;
        TxAbort = 1'b0;
        repeat (3) @(negedge MTxClk);
        check("rst_en", MTxEn, 0);
        check("rst_d", MTxD, 0);
        check("rst_req", TxDataReq, 0);
        check("rst_busy", TxBusy, 0);
        check("rst_done", TxDone, 0);
        check("rst_flags", {StateIfg, StateFrmCrc, StateData, StateSoC, StatePreamble, StateIdle}, 6'b000001);
        Reset = 1'b1;
        @(negedge MTxClk);

        pay[0] = 8'h3A;
        run_frame("numb", 1, 1, -1, 0);

        for (int i = 0; i < 12; i++) pay[i] = 8'(i);
        run_frame("data12", 0, 12, -1, 1);

        run_frame("dist0", 2, 0, -1, 0);

        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        run_frame("len255", 3, 255, -1, 0);

        run_frame("abort", 0, 12, 4, 0);

        for (int k = 0; k < 5; k++) begin
            int t, l;
            t = $urandom_range(0, 4);
            l = $urandom_range(0, 40);
            for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
            run_frame($sformatf("rnd%0d", k), t, l, -1, 1);
        end

        // Invalid frame type must be ignored entirely.
        @(negedge MTxClk);
        TxStart = 1'b1;
        TxType  = 3'd6;
        TxLen   = 8'd3;
        cnt = 0;
        repeat (6) begin
            @(negedge MTxClk);
            if (TxBusy !== 1'b0 || MTxEn !== 1'b0) cnt++;
        end
        TxStart = 1'b0;
        check("inv_busy", cnt, 0);

        // Back-to-back with TxStart held: gap is IFG plus the one IDLE cycle.
        @(negedge MTxClk);
        TxStart = 1'b1;
        TxType  = 3'd1;
        TxLen   = 8'd0;
        cnt = 0;
        while (MTxEn !== 1'b1 && cnt < 20) begin @(negedge MTxClk); cnt++; end
        while (MTxEn === 1'b1 && cnt < 40) begin @(negedge MTxClk); cnt++; end
        cnt = 0;
        while (MTxEn !== 1'b1 && cnt < 30) begin @(negedge MTxClk); cnt++; end
        check("b2b_gap", cnt, IFG + 1);
        TxStart = 1'b0;
        cnt = 0;
        while (TxBusy === 1'b1 && cnt < 40) begin @(negedge MTxClk); cnt++; end
        check("b2b_end", TxBusy, 0);

        // Asynchronous reset in the middle of payload.
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        TxData = pay[0];
        @(negedge MTxClk);
        TxStart = 1'b1;
        TxType  = 3'd0;
        TxLen   = 8'd20;
        @(negedge MTxClk);
        TxStart = 1'b0;
        repeat (12) @(negedge MTxClk);
        check("pre_rst_data", StateData, 1);
        #2 Reset = 1'b0;
        #1;
        check("arst_en", MTxEn, 0);
        check("arst_d", MTxD, 0);
        check("arst_busy", TxBusy, 0);
        check("arst_idle", StateIdle, 1);
        @(negedge MTxClk);
        Reset = 1'b1;
        pay[0] = 8'h3A;
        run_frame("post_rst", 1, 1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_txmac.md
Name: fb_txmac

Overview:
- Nibble-wide transmit MAC for the FREEDM bus; the transmit counterpart of the bus receive path.
- Serialises one frame per request: preamble, start-of-frame-code (SoC) nibble identifying the frame type, payload bytes low nibble first, then an 8-bit frame CRC.
- Sits between the master frame scheduler / TX RAM and the MII-style nibble transmit pins of DE2_115_MASTER.

Parameters:
- PREAMBLE_NIBS, 7, number of 4'h5 preamble nibbles sent before SoC (1..15).
- IFG_NIBS, 4, minimum idle cycles (MTxEn low) after the last CRC nibble before the next frame (1..15).

Ports:
- MTxClk  in  1  transmit nibble clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset (low = reset).
- TxStart  in  1  request a frame; sampled only in IDLE.
- TxType  in  3  frame type: 0 data (SoC 7), 1 numbering (SoC 6), 2 distribute (SoC 4), 3 delay (SoC 3), 4 delay-dist (SoC 2); 5..7 invalid.
- TxLen  in  8  payload byte count, 0..255.
- TxData  in  8  payload byte; must be valid in any cycle TxDataReq is high (show-ahead source).
- TxDataReq  out  1  byte fetch strobe; TxData captured at the same clock edge.
- TxAbort  in  1  abandon the current frame.
- MTxEn  out  1  transmit enable.
- MTxD  out  4  transmit nibble.
- TxBusy  out  1  frame in progress, including IFG.
- TxDone  out  1  one-cycle pulse on normal frame completion.
- StateIdle, StatePreamble, StateSoC, StateData, StateFrmCrc, StateIfg  out  1 each  one-hot state flags for debug/LEDs.

Behaviour:
- Reset values: MTxEn=0, MTxD=0, TxDataReq=0, TxBusy=0, TxDone=0, StateIdle=1, all other state flags 0. Reset is asynchronous and aborts any frame in flight immediately.
- States: IDLE, PREAMBLE, SOC, DATA, FRMCRC, IFG.
- TxType and TxLen are latched when the frame is accepted. Inputs are ignored after that.
- IDLE:
  - If TxStart=1 and TxType<=4, go to PREAMBLE. TxBusy rises in the next cycle.
  - If TxType is invalid, the request is ignored and the block stays in IDLE.
- PREAMBLE: MTxEn=1, MTxD=4'h5 for PREAMBLE_NIBS cycles, then go to SOC.
- SOC:
  - MTxD = SoC code for one cycle.
  - If TxLen>0, TxDataReq=1 in this cycle (fetches byte 0) and next state is DATA. Otherwise next state is FRMCRC.
- DATA:
  - Emits 2*TxLen nibbles from the latched byte: low nibble first, then high nibble.
  - TxDataReq=1 during each high-nibble cycle except the last byte's.
  - Exactly TxLen strobes per frame.
  - The 9-bit nibble counter must not wrap: TxLen=255 gives 510 data nibbles.
- CRC:
  - Computed with the codebase's fb_crc, driven with Reset inverted.
  - Initialize: asserted in IDLE.
  - Enable: asserted while MTxEn=1 and not in FRMCRC.
  - Data: MTxD.
  - Coverage is preamble, SoC and payload nibbles.
- FRMCRC: two cycles, CRC held.
  - 1st nibble: MTxD = {~Crc[4],~Crc[5],~Crc[6],~Crc[7]}.
  - 2nd nibble: MTxD = {~Crc[0],~Crc[1],~Crc[2],~Crc[3]}.
  - Then go to IFG.
- IFG:
  - MTxEn=0 and MTxD=0 for IFG_NIBS cycles, then go to IDLE.
  - TxDone=1 in the first IFG cycle.
  - TxBusy stays high through the last IFG cycle.
- MTxD=0 whenever MTxEn=0.
- TxAbort:
  - In PREAMBLE, SOC, DATA or FRMCRC, the next state is IFG. MTxEn drops at that edge, no TxDone is pulsed, and no further TxDataReq is issued.
  - TxAbort has no effect in IDLE or IFG.
- TxStart while TxBusy=1 is ignored and not queued.
- Back-to-back frames: with TxStart held high, the next preamble starts the cycle after IDLE is entered. Minimum spacing between frames is IFG_NIBS+1 idle cycles.

Decomposition:
- Package fb_pkg holds:
  - SoC nibble constants: FB_SOC_DATA=7, FB_SOC_NUMB=6, FB_SOC_DIST=4, FB_SOC_DELAY=3, FB_SOC_DELAYDIST=2.
  - FB_PREAMBLE_NIB=5.
  - The TxType encoding.
  - State encoding.
- Sub-module: reuse the existing fb_crc, one instance. No other sub-module.

Test Plan:
- Numbering frame (TxType=1, TxLen=1, TxData=8'h3A) -> MTxEn high 12 cycles; MTxD = 5,5,5,5,5,5,5,6,A,3, then 2 CRC nibbles matching a bench fb_crc model; one TxDataReq in the SoC cycle; TxDone 1 cycle after.
- Data frame (TxType=0, TxLen=12, bytes 0x00..0x0B) -> 24 data nibbles 0,0,1,0,...,B,0; exactly 12 TxDataReq strobes; total MTxEn length 7+1+24+2=34 cycles.
- TxLen=0 distribute frame -> preamble, SoC 4, 2 CRC nibbles, no TxDataReq; TxLen=255 -> 510 data nibbles and no counter wrap.
- TxAbort asserted on the 5th data nibble -> MTxEn low at the next edge, no TxDone, IFG_NIBS idle cycles, then accepts a new TxStart.
- Invalid TxType=6 with TxStart -> no activity, TxBusy stays 0. TxStart during a frame is ignored.
- Reset driven low mid-DATA -> MTxEn, MTxD, TxBusy immediately 0. After release, a numbering frame has correct CRC, showing CRC state was reinitialised.
